// File: rtl/seq_shifter.sv
// Multicycle shifter: loads an operand, shifts one bit per clock, pulses done.
// Define SEQ_SHIFTER_ROTATE_EN to enable op 100 (rotate right).
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               op_shifts;

  // Load-only and unsupported ops still run the FSM, just with zero shifts.
  always_comb begin
    op_shifts = 1'b0;
    case (op)
      OP_SLL:  op_shifts = 1'b1;
      OP_SRL:  op_shifts = 1'b1;
      OP_SRA:  op_shifts = 1'b1;
      OP_ROR:  op_shifts = ROT_EN;
      default: op_shifts = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          data_d  = data_in;
          op_d    = op;
          cnt_d   = op_shifts ? shamt : '0;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
          case (op_q)
            OP_SLL:  data_d = {data_q[WIDTH-2:0], 1'b0};
            OP_SRL:  data_d = {1'b0, data_q[WIDTH-1:1]};
            OP_SRA:  data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            OP_ROR:  data_d = {data_q[0], data_q[WIDTH-1:1]};
            default: data_d = data_q;
          endcase
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_LOAD;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign data_out = data_q;
  assign busy     = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: driver pushes expected results,
// monitor pops and compares on every done pulse.
module tb_seq_shifter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   errors;
  int   checks;

  seq_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .shamt    (shamt),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  logic prev_done;
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (prev_done) begin
        checks++;
        errors++;
        $display("FAIL done_width: done high two cycles, got 2 required 1");
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done at cycle %0d required none",
                 cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_data"}, data_out, e.data);
        check({e.name, "_cyc"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "_busy"}, {31'd0, busy}, 32'd1);
      end
    end
    prev_done <= (done === 1'b1);
  end

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(sb.size() == 0 && busy == 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      sb.delete();
      $display("FAIL %s_timeout: got busy after %0d cycles required idle",
               name, n);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o,
                        input logic [4:0] s, input logic [31:0] d,
                        input logic [31:0] exp, input int n);
    exp_t e;
    op      = o;
    shamt   = s;
    data_in = d;
    start   = 1'b1;
    e.data  = exp;
    e.cyc   = cyc + n + 2;
    e.name  = name;
    sb.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    op      = 3'b000;
    shamt   = '0;
    data_in = '0;
    wait_idle(name, n + 10);
  endtask

  initial begin
    exp_t e;
    errors  = 0;
    checks  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 3'b000;
    shamt   = '0;
    data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("sll4", 3'b001, 5'd4, 32'h0000_0001, 32'h0000_0010, 4);
    run_op("sra16", 3'b011, 5'd16, 32'h8000_0000, 32'hFFFF_8000, 16);
    run_op("sll8", 3'b001, 5'd8, 32'hDEAD_BEEF, 32'hADBE_EF00, 8);
    run_op("srl4", 3'b010, 5'd4, 32'hDEAD_BEEF, 32'h0DEA_DBEE, 4);
    run_op("sra31p", 3'b011, 5'd31, 32'h7000_0000, 32'h0000_0000, 31);
    run_op("sra31n", 3'b011, 5'd31, 32'h8000_0001, 32'hFFFF_FFFF, 31);
    run_op("load", 3'b000, 5'd7, 32'h1234_5678, 32'h1234_5678, 0);
    run_op("illegal", 3'b111, 5'd9, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
`ifdef SEQ_SHIFTER_ROTATE_EN
    run_op("ror1", 3'b100, 5'd1, 32'h0000_0003, 32'h8000_0001, 1);
`else
    run_op("ror1", 3'b100, 5'd1, 32'h0000_0003, 32'h0000_0003, 0);
`endif

    // SRL by zero with start re-pulsed during SHIFT and DONE
    op      = 3'b010;
    shamt   = 5'd0;
    data_in = 32'hF000_000F;
    start   = 1'b1;
    e.data  = 32'hF000_000F;
    e.cyc   = cyc + 2;
    e.name  = "srl0";
    sb.push_back(e);
    @(negedge clk);
    op      = 3'b001;
    shamt   = 5'd5;
    data_in = 32'h1111_1111;
    @(negedge clk);
    @(negedge clk);
    start   = 1'b0;
    wait_idle("srl0", 10);
    repeat (5) @(negedge clk);
    check("srl0_hold", data_out, 32'hF000_000F);
    check("srl0_idle", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high
    op      = 3'b010;
    shamt   = 5'd31;
    data_in = 32'hFFFF_FFFF;
    start   = 1'b1;
    e.data  = 32'h0000_0001;
    e.cyc   = cyc + 33;
    e.name  = "b2b_a";
    sb.push_back(e);
    e.cyc   = cyc + 67;
    e.name  = "b2b_b";
    sb.push_back(e);
    repeat (35) @(negedge clk);
    start = 1'b0;
    wait_idle("b2b", 50);

    // Reset aborting an SLL mid-operation
    op      = 3'b001;
    shamt   = 5'd10;
    data_in = 32'h0000_0001;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_data", data_out, 32'h0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (15) @(negedge clk);
    check("abort_idle", {31'd0, busy}, 32'd0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d pending results required 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
